// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that serialises four 16-bit request words onto a byte transmitter.
// Optional UART_ARB_ID_EN prefixes each word with a 0xA0|index header byte.
module uart_tx_arbiter #(
    parameter int BUSY_WAIT = 16
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [3:0]  req,
    input  logic [63:0] req_data,
    output logic [3:0]  grant,
    output logic [3:0]  ack,
    output logic        arb_busy,
    output logic        uart_en,
    output logic [7:0]  uart_din,
    input  logic        uart_tx_busy
);
    typedef enum logic [2:0] {IDLE, ARB, ISSUE, WAIT_RISE, WAIT_FALL, DONE} state_t;

    localparam int TW = (BUSY_WAIT > 1) ? $clog2(BUSY_WAIT) : 1;

    state_t          state_q, state_d;
    logic [3:0]      grant_q, grant_d;
    logic [3:0]      ack_q, ack_d;
    logic            arb_busy_q, arb_busy_d;
    logic [7:0]      uart_din_q, uart_din_d;
    logic [15:0]     buf_q, buf_d;
    logic [1:0]      left_q, left_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [1:0]      rr_ptr_q, rr_ptr_d;
    logic [1:0]      sel_q, sel_d;

    logic            found;
    logic [1:0]      idx;
    logic [15:0]     word;

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        ack_d      = '0;
        uart_din_d = uart_din_q;
        buf_d      = buf_q;
        left_d     = left_q;
        timer_d    = '0;
        rr_ptr_d   = rr_ptr_q;
        sel_d      = sel_q;
        found      = 1'b0;
        idx        = '0;
        word       = '0;

        case (state_q)
            IDLE: begin
                if (|req) state_d = ARB;
            end
            ARB: begin
                // rr_ptr_q names the requester with highest priority this round
                for (int unsigned i = 0; i < 4; i++) begin
                    idx = rr_ptr_q + 2'(i);
                    if (!found && req[idx]) begin
                        found = 1'b1;
                        sel_d = idx;
                    end
                end
                if (found) begin
                    grant_d = 4'b0001 << sel_d;
                    word    = req_data[{sel_d, 4'b0000} +: 16];
`ifdef UART_ARB_ID_EN
                    uart_din_d = 8'hA0 | {6'b000000, sel_d};
                    buf_d      = word;
                    left_d     = 2'd2;
`else
                    uart_din_d = word[7:0];
                    buf_d      = {8'h00, word[15:8]};
                    left_d     = 2'd1;
`endif
                    state_d = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                if (!uart_tx_busy) state_d = WAIT_RISE;
            end
            WAIT_RISE: begin
                if (uart_tx_busy || timer_q == TW'(BUSY_WAIT - 1)) begin
                    state_d = WAIT_FALL;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            WAIT_FALL: begin
                if (!uart_tx_busy) begin
                    if (left_q == 2'd0) begin
                        ack_d   = grant_q;
                        grant_d = '0;
                        state_d = DONE;
                    end else begin
                        uart_din_d = buf_q[7:0];
                        buf_d      = {8'h00, buf_q[15:8]};
                        left_d     = left_q - 1'b1;
                        state_d    = ISSUE;
                    end
                end
            end
            DONE: begin
                rr_ptr_d = sel_q + 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        arb_busy_d = (state_d != IDLE);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            ack_q      <= '0;
            arb_busy_q <= 1'b0;
            uart_din_q <= '0;
            buf_q      <= '0;
            left_q     <= '0;
            timer_q    <= '0;
            rr_ptr_q   <= '0;
            sel_q      <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            ack_q      <= ack_d;
            arb_busy_q <= arb_busy_d;
            uart_din_q <= uart_din_d;
            buf_q      <= buf_d;
            left_q     <= left_d;
            timer_q    <= timer_d;
            rr_ptr_q   <= rr_ptr_d;
            sel_q      <= sel_d;
        end
    end

    // uart_en must qualify on the live busy flag so the strobe only lands in a not-busy ISSUE cycle
    assign uart_en  = (state_q == ISSUE) && !uart_tx_busy;
    assign grant    = grant_q;
    assign ack      = ack_q;
    assign arb_busy = arb_busy_q;
    assign uart_din = uart_din_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: expected bytes/grants/acks queued at stimulus time.
// Honours UART_ARB_ID_EN to expect the header byte.
module tb_uart_tx_arbiter;
    localparam int BW = 16;
`ifdef UART_ARB_ID_EN
    localparam int NB = 3;
`else
    localparam int NB = 2;
`endif

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic [3:0]  req = '0;
    logic [63:0] req_data = '0;
    logic [3:0]  grant, ack;
    logic        arb_busy, uart_en;
    logic [7:0]  uart_din;
    logic        uart_tx_busy;

    logic busy_model = 1'b0;
    logic tx_hold    = 1'b0;
    logic tx_respond = 1'b1;
    logic en_flag    = 1'b0;
    int   busy_len   = 10;
    assign uart_tx_busy = busy_model | tx_hold;

    int n_cmp = 0, n_err = 0;
    int cyc = 0, bytes_seen = 0, acks_seen = 0, last_en_cyc = 0, last_gap = 0;
    logic [7:0] exp_bytes[$];
    logic [3:0] exp_acks[$];
    logic [3:0] exp_grants[$];

    uart_tx_arbiter #(.BUSY_WAIT(BW)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .req(req), .req_data(req_data),
        .grant(grant), .ack(ack), .arb_busy(arb_busy), .uart_en(uart_en),
        .uart_din(uart_din), .uart_tx_busy(uart_tx_busy)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_xfer(input int i, input logic [15:0] w, input bit with_ack);
        logic [3:0] oh;
        oh = 4'b0001 << i;
`ifdef UART_ARB_ID_EN
        exp_bytes.push_back(8'hA0 | 8'(i));
`endif
        exp_bytes.push_back(w[7:0]);
        exp_bytes.push_back(w[15:8]);
        exp_grants.push_back(oh);
        if (with_ack) exp_acks.push_back(oh);
    endtask

    task automatic wait_count(input string tag, input bit on_acks, input int target, input int budget);
        int k = 0;
        while (((on_acks ? acks_seen : bytes_seen) < target) && k < budget) begin
            @(posedge sys_clk); #1; k++;
        end
        check(tag, 64'((on_acks ? acks_seen : bytes_seen) >= target), 64'd1);
    endtask

    task automatic step(input int n);
        repeat (n) begin @(posedge sys_clk); #1; end
    endtask

    initial forever begin
        @(posedge sys_clk);
        cyc++;
    end

    // Byte transmitter model: busy for busy_len cycles starting the cycle after a strobe
    initial begin
        int busy_cnt = 0;
        forever begin
            @(posedge sys_clk); #1;
            if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) busy_model = 1'b0;
            end
            if (en_flag) begin
                en_flag = 1'b0;
                if (tx_respond) begin
                    busy_model = 1'b1;
                    busy_cnt   = busy_len;
                end
            end
        end
    end

    initial begin
        logic       prev_en = 1'b0;
        logic [3:0] prev_grant = '0;
        forever begin
            @(negedge sys_clk);
            if (!sys_rst) begin
                check("grant_onehot", 64'($onehot0(grant)), 64'd1);
                check("ack_onehot", 64'($onehot0(ack)), 64'd1);
                check("ack_grant_overlap", 64'(ack & grant), 64'd0);
                if (uart_en === 1'b1) begin
                    en_flag = 1'b1;
                    check("en_single_cycle", 64'(prev_en), 64'd0);
                    n_cmp++;
                    assert (exp_bytes.size() > 0) else begin
                        n_err++;
                        $error("FAIL byte_unexpected: observed %0h expected none", uart_din);
                    end
                    if (exp_bytes.size() > 0) check("byte", 64'(uart_din), 64'(exp_bytes.pop_front()));
                    bytes_seen++;
                    last_gap    = cyc - last_en_cyc;
                    last_en_cyc = cyc;
                end
                if (ack !== 4'b0000) begin
                    n_cmp++;
                    assert (exp_acks.size() > 0) else begin
                        n_err++;
                        $error("FAIL ack_unexpected: observed %0h expected none", ack);
                    end
                    if (exp_acks.size() > 0) check("ack", 64'(ack), 64'(exp_acks.pop_front()));
                    acks_seen++;
                end
                if (grant !== 4'b0000 && prev_grant === 4'b0000) begin
                    n_cmp++;
                    assert (exp_grants.size() > 0) else begin
                        n_err++;
                        $error("FAIL grant_unexpected: observed %0h expected none", grant);
                    end
                    if (exp_grants.size() > 0) check("grant", 64'(grant), 64'(exp_grants.pop_front()));
                end
            end
            prev_en    = uart_en;
            prev_grant = grant;
        end
    end

    initial begin
        repeat (60000) @(posedge sys_clk);
        $display("FAIL watchdog: observed no completion expected finish within 60000 cycles");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, b0;
        step(3);
        sys_rst = 1'b0;
        check("rst_grant", 64'(grant), 64'd0);
        check("rst_ack", 64'(ack), 64'd0);
        check("rst_uart_en", 64'(uart_en), 64'd0);
        check("rst_uart_din", 64'(uart_din), 64'd0);
        check("rst_arb_busy", 64'(arb_busy), 64'd0);

        // Single requester, latency, data change after latch
        req_data[15:0] = 16'h1234;
        push_xfer(0, 16'h1234, 1'b1);
        b0 = bytes_seen; c0 = cyc;
        req = 4'b0001;
        wait_count("first_byte", 1'b0, b0 + 1, 50);
        check("issue_latency", 64'(last_en_cyc - c0), 64'd2);
        req_data[15:0] = 16'hFFFF;
        wait_count("ack_s1", 1'b1, 1, 300);
        req = 4'b0000;
        step(2);
        check("arb_busy_idle", 64'(arb_busy), 64'd0);

        // Round robin from reset with all four requesters held
        sys_rst = 1'b1; step(2); sys_rst = 1'b0;
        req_data = {16'h0303, 16'h0202, 16'h0101, 16'h0000};
        for (int i = 0; i < 5; i++) push_xfer(i % 4, 16'(i % 4) * 16'h0101, 1'b1);
        req = 4'b1111;
        wait_count("ack_rr", 1'b1, 6, 2000);
        req = 4'b0000;
        step(3);

        // Transmitter never raises busy: every byte times out
        tx_respond = 1'b0;
        req_data[31:16] = 16'hCAFE;
        push_xfer(1, 16'hCAFE, 1'b1);
        req = 4'b0010;
        wait_count("ack_timeout", 1'b1, 7, 300);
        req = 4'b0000;
        check("timeout_gap", 64'(last_gap), 64'(BW + 2));
        tx_respond = 1'b1;
        step(3);

        // Busy already high at grant; req dropped mid-transfer
        tx_hold = 1'b1;
        req_data[47:32] = 16'h5AA5;
        push_xfer(2, 16'h5AA5, 1'b1);
        b0 = bytes_seen;
        req = 4'b0100;
        step(8);
        check("stall_no_byte", 64'(bytes_seen), 64'(b0));
        check("stall_en_low", 64'(uart_en), 64'd0);
        tx_hold = 1'b0;
        wait_count("stall_first", 1'b0, b0 + 1, 20);
        req = 4'b0000;
        wait_count("ack_stall", 1'b1, 8, 300);
        step(3);

        req_data[47:32] = 16'hBEEF;
        push_xfer(2, 16'hBEEF, 1'b1);
        req = 4'b0100;
        wait_count("ack_beef", 1'b1, 9, 300);
        req = 4'b0000;
        step(3);

        // Reset while waiting for busy to fall after the high byte
        req_data[63:48] = 16'h7788;
        push_xfer(3, 16'h7788, 1'b1);
        b0 = bytes_seen;
        req = 4'b1000;
        wait_count("abort_bytes", 1'b0, b0 + NB, 300);
        step(2);
        sys_rst = 1'b1;
        step(1);
        check("abort_grant", 64'(grant), 64'd0);
        check("abort_ack", 64'(ack), 64'd0);
        check("abort_uart_en", 64'(uart_en), 64'd0);
        check("abort_uart_din", 64'(uart_din), 64'd0);
        check("abort_arb_busy", 64'(arb_busy), 64'd0);
        check("abort_ack_pending", 64'(exp_acks.size()), 64'd1);
        sys_rst = 1'b0;
        push_xfer(3, 16'h7788, 1'b0);
        wait_count("ack_reserve", 1'b1, 10, 300);
        req = 4'b0000;
        step(5);

        check("bytes_left", 64'(exp_bytes.size()), 64'd0);
        check("acks_left", 64'(exp_acks.size()), 64'd0);
        check("grants_left", 64'(exp_grants.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
